prng_word_collector: RTL
========================

Name: prng_word_collector

Overview:
- Consumes the serial pseudo-random bit stream from the 4-bit LFSR stage and packs it MSB-first into WORD_W-bit words.
- Buffers completed words in a small FIFO with a valid/ready output for downstream consumers (UART TX, LED pattern logic).
- Counts delivered words and flags dropped words.
- Optionally monitors the stream for a stuck generator.

Parameters:
- WORD_W, 8, bits per assembled word (≥2)
- FIFO_DEPTH, 4, word FIFO entries (power of 2, ≥2)
- STUCK_LEN, 16, consecutive identical bits that count as a stuck stream (optional feature only)

Ports:
- CLK  in  1  system clock, all logic on rising edge
- BTN_N  in  1  asynchronous active-low reset
- bit_in  in  1  serial random bit from LFSR stage
- bit_en  in  1  sample strobe; bit_in accepted on a CLK edge where bit_en=1
- out_data  out  WORD_W  FIFO head word
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head when out_valid & out_ready
- overflow  out  1  sticky: a completed word was dropped
- word_cnt  out  16  words successfully pushed into the FIFO, wraps 0xFFFF→0
- stuck  out  1  stuck-stream indicator (0 when feature compiled out)

Behaviour:
- Reset (BTN_N=0, asynchronous assert, synchronous-to-CLK release effect): shift reg=0, bit counter=0, FIFO empty, out_data=0, out_valid=0, overflow=0, word_cnt=0, stuck=0. Reset mid-word discards partial bits.
- Assembly: on each accepted bit, shift_reg <= {shift_reg[WORD_W-2:0], bit_in}; bit counter increments. First accepted bit ends up as the word MSB.
- Word completion: on the edge accepting the WORD_W-th bit:
  - word = {shift_reg[WORD_W-2:0], bit_in} is pushed the same edge.
  - Bit counter returns to 0. No bubble: the next bit may be accepted on the following edge.
- Latency: out_valid rises 1 cycle after the completing edge when the FIFO was empty.
- FIFO: out_data always shows the head entry, and is 0 when empty. Pop occurs on an edge where out_valid & out_ready.
- Boundary conditions:
  - Full + push + pop on the same edge: both succeed, no overflow, occupancy unchanged.
  - Full + push without pop: word dropped, overflow <= 1 (held until reset), word_cnt unchanged.
  - Empty + push + out_ready=1: word is not popped that edge (out_valid still 0); it is popped no earlier than the next edge.
  - out_ready with FIFO empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH; an extra occupancy bit distinguishes full from empty.
- word_cnt: increments on each successful push only.
- bit_en=0: shift reg, counter and stuck logic hold; FIFO pops still proceed.

Optional Feature:
- Macro: PRNG_STUCK_DETECT_EN
- Defined:
  - Run-length counter tracks consecutive identical accepted bits (saturating at STUCK_LEN).
  - stuck=1 from the edge where the run reaches STUCK_LEN.
  - stuck clears on the edge accepting a differing bit (run restarts at 1). Reset clears it.
  - A healthy maximal 4-bit LFSR never exceeds a run of 4.
- Undefined: no run-length logic synthesized; stuck tied to 0; port list unchanged.

Test Plan:
- Basic word: out_ready=1, bit_en=1 continuous, bits 1,0,1,1,0,0,1,0 → out_data=0xB2, out_valid high for exactly 1 cycle starting 1 cycle after 8th bit; word_cnt=1; overflow=0.
- Gapped strobe: same 8 bits with bit_en=0 for 3 cycles between each bit → identical 0xB2 result; no extra words.
- Overflow: out_ready=0, feed words 0x01,0x02,0x03,0x04,0x05 → overflow=1 after 0x05's last bit, word_cnt=4; then out_ready=1 drains 0x01,0x02,0x03,0x04, then out_valid=0; overflow stays 1.
- Simultaneous push/pop at full: FIFO holds 0x01–0x04, out_ready pulsed on the edge completing 0x05 → overflow=0, word_cnt=5, drain order 0x02,0x03,0x04,0x05.
- Reset mid-word: 5 bits fed, BTN_N pulsed low, then 8 bits forming 0xA5 → single output word 0xA5, word_cnt=1.
- Stuck (macro defined): 16 consecutive 1s → stuck=1 on 16th accepted bit edge; next bit 0 → stuck=0; macro undefined → stuck stays 0 throughout.

Source files
------------

// File: rtl/prng_word_collector.sv
// prng_word_collector: packs the LFSR serial bit stream MSB-first into words and queues them.
// Optional stuck-stream monitor is compiled in with `define PRNG_STUCK_DETECT_EN.
module prng_word_collector #(
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int STUCK_LEN  = 16
) (
    input  logic              CLK,
    input  logic              BTN_N,
    input  logic              bit_in,
    input  logic              bit_en,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow,
    output logic [15:0]       word_cnt,
    output logic              stuck
);

    localparam int CNT_W = $clog2(WORD_W);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PW    = AW + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    if (WORD_W < 2 || FIFO_DEPTH < 2 || STUCK_LEN < 1 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("prng_word_collector: illegal parameter set");
    end

    // Only the WORD_W-1 oldest bits need storing; the newest bit comes from bit_in.
    logic [WORD_W-2:0] part;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] word;
    logic              word_done;

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              empty;
    logic              full;
    logic              pop;
    logic              push;

    assign word      = {part, bit_in};
    assign word_done = bit_en && (bit_cnt == LAST_BIT);

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                   (wr_ptr[AW] != rd_ptr[AW]);

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    // A full FIFO still takes the new word when the head leaves on the same edge.
    assign push      = word_done && (!full || pop);
    assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Shift accepted bits in and count them; counter wraps to 0 on the completing bit.
    always_ff @(posedge CLK or negedge BTN_N) begin
        if (!BTN_N) begin
            part    <= '0;
            bit_cnt <= '0;
        end else if (bit_en) begin
            part    <= word[WORD_W-2:0];
            bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
        end
    end

    // Word storage; contents are don't-care until written, so no reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= word;
        end
    end

    // FIFO pointers, delivered-word counter and sticky drop flag.
    always_ff @(posedge CLK or negedge BTN_N) begin
        if (!BTN_N) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            word_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                word_cnt <= word_cnt + 16'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (word_done && !push) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef PRNG_STUCK_DETECT_EN
    localparam int RW = $clog2(STUCK_LEN + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(STUCK_LEN);

    logic [RW-1:0] run_len;
    logic [RW-1:0] run_next;
    logic          last_bit;

    // Next run length: restart at 1 on a new value, saturate at RUN_MAX.
    always_comb begin
        run_next = RW'(1);
        if (run_len != '0 && bit_in == last_bit) begin
            run_next = (run_len == RUN_MAX) ? RUN_MAX : run_len + 1'b1;
        end
    end

    // Track the run of identical accepted bits and flag a stuck generator.
    always_ff @(posedge CLK or negedge BTN_N) begin
        if (!BTN_N) begin
            run_len  <= '0;
            last_bit <= 1'b0;
            stuck    <= 1'b0;
        end else if (bit_en) begin
            run_len  <= run_next;
            last_bit <= bit_in;
            stuck    <= (run_next == RUN_MAX);
        end
    end
`else
    assign stuck = 1'b0;
`endif

endmodule
